// File: rtl/bus_slave_responder.sv
// ============================================================================
// Module   : bus_slave_responder
// Purpose  : AZPR bus slave endpoint with a scratchpad memory and programmable
//            wait states. Optional macro BUS_SLAVE_ADDR_CHECK_EN flags accesses
//            with non-zero upper address bits as out of range.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_slave_responder #(
    parameter int DEPTH       = 16,
    parameter int IDX_W       = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        as_n,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_n
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [3:0]  c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] c_oor_data  = 32'hDEAD_BEEF;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_rw;
    logic [3:0]       r_cnt;
    logic [31:0]      r_mem [DEPTH];

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic [31:0]      w_rd_word;

    assign w_accept = (r_state == S_IDLE) && !cs_n && !as_n;
    assign w_idx    = addr[IDX_W-1:0];

`ifdef BUS_SLAVE_ADDR_CHECK_EN
    logic r_oor;

    assign w_in_range = (addr[29:IDX_W] == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_oor <= 1'b0;
        end else if (w_accept) begin
            r_oor <= !w_in_range;
        end
    end

    assign w_rd_word = r_oor ? c_oor_data : r_mem[r_idx];
`else
    // Upper address bits alias onto the scratchpad modulo DEPTH.
    assign w_in_range = 1'b1;
    assign w_rd_word  = r_mem[r_idx];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_rw    <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx <= w_idx;
                r_rw  <= rw;
                r_cnt <= c_wait_load;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Writes commit on the accept edge so a read in READY sees fresh data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && !rw && w_in_range) begin
            r_mem[w_idx] <= wr_data;
        end
    end

    always_comb begin
        w_next  = r_state;
        rdy_n   = 1'b1;
        rd_data = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_READY;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_READY;
                end
            end
            S_READY: begin
                rdy_n  = 1'b0;
                w_next = S_IDLE;
                // Zero outside the ready cycle keeps OR-based slave muxing safe.
                if (r_rw) begin
                    rd_data = w_rd_word;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_slave_responder.sv
// ============================================================================
// Module   : tb_bus_slave_responder
// Purpose  : Directed self-checking bench; one instance with WAIT_CYCLES=0 and
//            one with WAIT_CYCLES=1, sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_slave_responder;

    logic        clk;
    logic        reset;
    logic        r_cs_n    [2];
    logic        r_as_n    [2];
    logic        r_rw      [2];
    logic [29:0] r_addr    [2];
    logic [31:0] r_wr_data [2];
    logic [31:0] w_rd_data [2];
    logic        w_rdy_n   [2];

    int n_tests  = 0;
    int n_fail   = 0;
    int zero_err = 0;

    bus_slave_responder #(.DEPTH(16), .IDX_W(4), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk     (clk),
        .reset   (reset),
        .cs_n    (r_cs_n[0]),
        .as_n    (r_as_n[0]),
        .rw      (r_rw[0]),
        .addr    (r_addr[0]),
        .wr_data (r_wr_data[0]),
        .rd_data (w_rd_data[0]),
        .rdy_n   (w_rdy_n[0])
    );

    bus_slave_responder #(.DEPTH(16), .IDX_W(4), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk     (clk),
        .reset   (reset),
        .cs_n    (r_cs_n[1]),
        .as_n    (r_as_n[1]),
        .rw      (r_rw[1]),
        .addr    (r_addr[1]),
        .wr_data (r_wr_data[1]),
        .rd_data (w_rd_data[1]),
        .rdy_n   (w_rdy_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; holds the request until rdy_n is seen low.
    task automatic access(input int s, input logic rw_i, input logic [29:0] a,
                          input logic [31:0] d, input bit corrupt,
                          output logic [31:0] rd, output int lat, output logic one_ok);
        r_cs_n[s]    = 1'b0;
        r_as_n[s]    = 1'b0;
        r_rw[s]      = rw_i;
        r_addr[s]    = a;
        r_wr_data[s] = d;
        @(posedge clk);
        lat = 0;
        rd  = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (corrupt && lat == 1) begin
                r_addr[s]    = 30'd7;
                r_rw[s]      = 1'b0;
                r_wr_data[s] = 32'hFFFF_FFFF;
            end
            if (w_rdy_n[s] == 1'b0) begin
                rd = w_rd_data[s];
                break;
            end
            if (w_rd_data[s] != 32'h0) zero_err++;
        end
        r_cs_n[s] = 1'b1;
        r_as_n[s] = 1'b1;
        r_rw[s]   = 1'b1;
        @(negedge clk);
        one_ok = w_rdy_n[s];
        if (w_rd_data[s] != 32'h0) zero_err++;
    endtask

    task automatic do_write(input int s, input logic [29:0] a, input logic [31:0] d, input string tag);
        logic [31:0] rd;
        int          lat;
        logic        one_ok;
        access(s, 1'b0, a, d, 1'b0, rd, lat, one_ok);
        check({tag, "_wlat"}, 32'(lat), 32'(s + 1));
        check({tag, "_wdata0"}, rd, 32'h0);
        check({tag, "_wpulse"}, {31'h0, one_ok}, 32'h1);
    endtask

    task automatic do_read(input int s, input logic [29:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        int          lat;
        logic        one_ok;
        access(s, 1'b1, a, 32'h0, 1'b0, rd, lat, one_ok);
        check({tag, "_rlat"}, 32'(lat), 32'(s + 1));
        check({tag, "_rdata"}, rd, exp);
        check({tag, "_rpulse"}, {31'h0, one_ok}, 32'h1);
    endtask

    initial begin
        int          bad;
        logic [31:0] rd;
        int          lat;
        logic        one_ok;

        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            r_cs_n[k] = 1'b1; r_as_n[k] = 1'b1; r_rw[k] = 1'b1;
            r_addr[k] = '0;   r_wr_data[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_rdy_n", {30'h0, w_rdy_n[1], w_rdy_n[0]}, 32'h3);
        check("reset_rd_data", w_rd_data[0] | w_rd_data[1], 32'h0);
        reset = 1'b1;

        // Idle, then half-strobes that must not start an access
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!w_rdy_n[0] || !w_rdy_n[1] || (w_rd_data[0] | w_rd_data[1]) != 0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'h0);
        r_cs_n[1] = 1'b0; r_as_n[0] = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (!w_rdy_n[0] || !w_rdy_n[1]) bad++;
        end
        r_cs_n[1] = 1'b1; r_as_n[0] = 1'b1;
        check("half_strobe", 32'(bad), 32'h0);
        do_read(0, 30'd3, 32'h0, "rst_w0_idx3");
        do_read(1, 30'd3, 32'h0, "rst_w1_idx3");

        do_write(1, 30'd5, 32'h1234_5678, "w1_a5");
        do_read(1, 30'd5, 32'h1234_5678, "w1_a5");

        // Inputs changed during WAIT must be ignored
        do_write(1, 30'd2, 32'h2222_0002, "w1_a2");
        do_write(1, 30'd7, 32'h7777_0007, "w1_a7");
        access(1, 1'b1, 30'd2, 32'h0, 1'b1, rd, lat, one_ok);
        check("wait_chg_lat", 32'(lat), 32'd2);
        check("wait_chg_data", rd, 32'h2222_0002);
        do_read(1, 30'd7, 32'h7777_0007, "wait_chg_a7");

        for (int i = 0; i < 16; i++) do_write(0, 30'(i), 32'(i * 3), "w0_sweep");
        for (int i = 0; i < 16; i++) do_read(0, 30'(i), 32'(i * 3), "w0_sweep");

        do_write(0, 30'd0, 32'h0000_1111, "alias_pre");
        do_write(0, 30'h10, 32'hA5A5_A5A5, "alias");
`ifdef BUS_SLAVE_ADDR_CHECK_EN
        do_read(0, 30'd0, 32'h0000_1111, "oor_mem0");
        do_read(0, 30'h10, 32'hDEAD_BEEF, "oor_read");
`else
        do_read(0, 30'd0, 32'hA5A5_A5A5, "alias_mem0");
        do_read(0, 30'h10, 32'hA5A5_A5A5, "alias_read");
`endif

        // Reset during WAIT: no ready pulse, scratchpad cleared
        r_cs_n[1] = 1'b0; r_as_n[1] = 1'b0; r_rw[1] = 1'b1; r_addr[1] = 30'd5;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        r_cs_n[1] = 1'b1; r_as_n[1] = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (!w_rdy_n[1]) bad++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!w_rdy_n[1]) bad++;
        end
        check("rst_mid_nordy", 32'(bad), 32'h0);
        do_read(1, 30'd5, 32'h0, "rst_mid_cleared");
        do_write(1, 30'd5, 32'hBEEF_0005, "rst_mid_after");
        do_read(1, 30'd5, 32'hBEEF_0005, "rst_mid_after");

        check("rd_zero_not_ready", 32'(zero_err), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
